// File: rtl/id_ex_shift_feed.sv
// id_ex_shift_feed: ID/EX register for SRL/SRLV with EX/MEM and MEM/WB operand forwarding into the shifter
module id_ex_shift_feed #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [AW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [SW-1:0] id_shamt,
  input  logic          id_var_shift,
  input  logic          id_reg_write,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [AW-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic [DW-1:0] ex_shift_val,
  output logic [DW-1:0] ex_shift_amt,
  output logic [1:0]    ex_fwd_val,
  output logic [1:0]    ex_fwd_amt
);
  logic          r_valid, r_reg_write, r_var_shift;
  logic [AW-1:0] r_rs_addr, r_rt_addr, r_rd_addr;
  logic [DW-1:0] r_rs_data, r_rt_data;
  logic [SW-1:0] r_shamt;
  logic [1:0]    w_sel_rt, w_sel_rs;
  logic [DW-1:0] w_rt, w_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_var_shift <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_shamt     <= '0;
    end else if (!stall_i) begin
      r_valid     <= id_valid;
      r_reg_write <= id_reg_write;
      r_var_shift <= id_var_shift;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd_addr   <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_shamt     <= id_shamt;
    end
  end

  // EX/MEM beats MEM/WB; register 0 always reads the captured value
  always_comb begin
    w_sel_rt = (exmem_reg_write && exmem_rd == r_rt_addr && r_rt_addr != '0) ? 2'b10 :
               (memwb_reg_write && memwb_rd == r_rt_addr && r_rt_addr != '0) ? 2'b01 : 2'b00;
    w_sel_rs = (exmem_reg_write && exmem_rd == r_rs_addr && r_rs_addr != '0) ? 2'b10 :
               (memwb_reg_write && memwb_rd == r_rs_addr && r_rs_addr != '0) ? 2'b01 : 2'b00;
    w_rt = w_sel_rt[1] ? exmem_result : w_sel_rt[0] ? memwb_result : r_rt_data;
    w_rs = w_sel_rs[1] ? exmem_result : w_sel_rs[0] ? memwb_result : r_rs_data;
  end

  assign ex_valid     = r_valid;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_valid & r_reg_write;
  assign ex_shift_val = w_rt;
  assign ex_shift_amt = {{(DW-SW){1'b0}}, r_var_shift ? w_rs[SW-1:0] : r_shamt};
  assign ex_fwd_val   = w_sel_rt;
  assign ex_fwd_amt   = r_var_shift ? w_sel_rs : 2'b00;
endmodule

// File: tb/tb_id_ex_shift_feed.sv
// tb_id_ex_shift_feed: vector table, directed corner sequences and randomized model checks
module tb_id_ex_shift_feed;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, id_valid = 1'b0;
  logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0, id_shamt = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0;
  logic        id_var_shift = 1'b0, id_reg_write = 1'b0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_result = '0, memwb_result = '0;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_shift_val, ex_shift_amt;
  logic [1:0]  ex_fwd_val, ex_fwd_amt;

  id_ex_shift_feed dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_shamt(id_shamt),
    .id_var_shift(id_var_shift), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_shift_val(ex_shift_val), .ex_shift_amt(ex_shift_amt),
    .ex_fwd_val(ex_fwd_val), .ex_fwd_amt(ex_fwd_amt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd; logic [4:0] sh; logic vs, rw;
  } ins_t;

  typedef struct {
    logic st, fl, v; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd; logic [4:0] sh; logic vs, rw;
    logic xw; logic [4:0] xrd; logic [31:0] xres; logic mw; logic [4:0] mrd; logic [31:0] mres;
    logic e_v; logic [4:0] e_rd; logic e_rw; logic [31:0] e_val, e_amt; logic [1:0] e_fv, e_fa;
  } vec_t;

  ins_t m;
  vec_t tbl[8];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {source, value} seen by an operand at register index a whose captured value is d
  function automatic logic [33:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && exmem_reg_write && exmem_rd == a) return {2'b10, exmem_result};
    if (a != 0 && memwb_reg_write && memwb_rd == a) return {2'b01, memwb_result};
    return {2'b00, d};
  endfunction

  task automatic check_model(input string tag);
    logic [33:0] fv, fa;
    fv = fwd(m.rt, m.rtd);
    fa = fwd(m.rs, m.rsd);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(m.v));
    chk({tag, ".rd"}, 64'(ex_rd_addr), 64'(m.rd));
    chk({tag, ".rw"}, 64'(ex_reg_write), 64'(m.v & m.rw));
    chk({tag, ".val"}, 64'(ex_shift_val), 64'(fv[31:0]));
    chk({tag, ".fv"}, 64'(ex_fwd_val), 64'(fv[33:32]));
    chk({tag, ".amt"}, 64'(ex_shift_amt), 64'(m.vs ? 32'(fa[4:0]) : 32'(m.sh)));
    chk({tag, ".fa"}, 64'(ex_fwd_amt), 64'(m.vs ? fa[33:32] : 2'b00));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush_i) m = '{default: '0};
    else if (!stall_i)
      m = '{id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
            id_shamt, id_var_shift, id_reg_write};
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd,
                          input logic [4:0] sh, input logic vs, rw);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_shamt = sh; id_var_shift = vs; id_reg_write = rw;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(0));
    chk({tag, ".rd"}, 64'(ex_rd_addr), 64'(0));
    chk({tag, ".rw"}, 64'(ex_reg_write), 64'(0));
    chk({tag, ".val"}, 64'(ex_shift_val), 64'(0));
    chk({tag, ".amt"}, 64'(ex_shift_amt), 64'(0));
    chk({tag, ".fv"}, 64'(ex_fwd_val), 64'(0));
    chk({tag, ".fa"}, 64'(ex_fwd_amt), 64'(0));
  endtask

  initial begin
    tbl[0] = '{1'b0,1'b0,1'b1, 5'd0,5'd5,5'd7, 32'h0,32'h8000_0000,5'd4,1'b0,1'b1,
               1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7,1'b1,32'h8000_0000,32'h4,2'b00,2'b00};
    tbl[1] = '{1'b0,1'b0,1'b1, 5'd3,5'd6,5'd8, 32'h100,32'h1234_5678,5'd9,1'b1,1'b1,
               1'b1,5'd3,32'h21, 1'b1,5'd3,32'h7, 1'b1,5'd8,1'b1,32'h1234_5678,32'h1,2'b00,2'b10};
    tbl[2] = '{1'b1,1'b0,1'b1, 5'd1,5'd1,5'd31, 32'hFFFF_FFFF,32'hFFFF_FFFF,5'd1,1'b0,1'b0,
               1'b0,5'd3,32'h21, 1'b1,5'd3,32'h7, 1'b1,5'd8,1'b1,32'h1234_5678,32'h7,2'b00,2'b01};
    tbl[3] = '{1'b0,1'b0,1'b1, 5'd0,5'd0,5'd9, 32'h0,32'h0,5'd2,1'b0,1'b1,
               1'b1,5'd0,32'hFFFF_FFFF, 1'b1,5'd0,32'hAAAA_AAAA, 1'b1,5'd9,1'b1,32'h0,32'h2,2'b00,2'b00};
    tbl[4] = '{1'b0,1'b0,1'b0, 5'd0,5'd4,5'd10, 32'h0,32'h55,5'd3,1'b0,1'b1,
               1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd10,1'b0,32'h55,32'h3,2'b00,2'b00};
    tbl[5] = '{1'b0,1'b0,1'b1, 5'd0,5'd12,5'd11, 32'h0,32'h1,5'd31,1'b0,1'b1,
               1'b1,5'd13,32'h1111_1111, 1'b1,5'd12,32'hDEAD_BEEF, 1'b1,5'd11,1'b1,32'hDEAD_BEEF,32'h1F,2'b01,2'b00};
    tbl[6] = '{1'b0,1'b0,1'b1, 5'd0,5'd2,5'd3, 32'h3F,32'hF0,5'd0,1'b1,1'b1,
               1'b1,5'd0,32'h5, 1'b0,5'd0,32'h0, 1'b1,5'd3,1'b1,32'hF0,32'h1F,2'b00,2'b00};
    tbl[7] = '{1'b0,1'b1,1'b1, 5'd2,5'd2,5'd2, 32'h9,32'h9,5'd7,1'b1,1'b1,
               1'b1,5'd2,32'h8, 1'b0,5'd0,32'h0, 1'b0,5'd0,1'b0,32'h0,32'h0,2'b00,2'b00};
    m = '{default: '0};

    // reset released while stalled: state stays empty until the first free edge
    stall_i = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 5'd4, 1'b0, 1'b1);
    #12 rst_n = 1'b1;
    tick(); tick();
    chk("rst_stall.valid", 64'(ex_valid), 64'(0));
    chk("rst_stall.rd", 64'(ex_rd_addr), 64'(0));
    stall_i = 1'b0;
    tick();
    check_model("load");
    chk("load.rd", 64'(ex_rd_addr), 64'(3));
    // asynchronous reset mid-cycle with an instruction loaded
    exmem_reg_write = 1'b1; exmem_rd = 5'd2; exmem_result = 32'hCAFE_F00D;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    m = '{default: '0};
    #1 rst_n = 1'b1;
    exmem_reg_write = 1'b0;

    for (int i = 0; i < 8; i++) begin
      stall_i = tbl[i].st; flush_i = tbl[i].fl;
      drive_id(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].rsd, tbl[i].rtd,
               tbl[i].sh, tbl[i].vs, tbl[i].rw);
      exmem_reg_write = tbl[i].xw; exmem_rd = tbl[i].xrd; exmem_result = tbl[i].xres;
      memwb_reg_write = tbl[i].mw; memwb_rd = tbl[i].mrd; memwb_result = tbl[i].mres;
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
      chk($sformatf("vec%0d.rd", i), 64'(ex_rd_addr), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d.rw", i), 64'(ex_reg_write), 64'(tbl[i].e_rw));
      chk($sformatf("vec%0d.val", i), 64'(ex_shift_val), 64'(tbl[i].e_val));
      chk($sformatf("vec%0d.amt", i), 64'(ex_shift_amt), 64'(tbl[i].e_amt));
      chk($sformatf("vec%0d.fv", i), 64'(ex_fwd_val), 64'(tbl[i].e_fv));
      chk($sformatf("vec%0d.fa", i), 64'(ex_fwd_amt), 64'(tbl[i].e_fa));
    end
    stall_i = 1'b0; flush_i = 1'b0; exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // three stalled cycles with changing ID, then flush together with stall
    drive_id(1'b1, 5'd0, 5'd9, 5'd14, 32'h0, 32'hABCD_0123, 5'd6, 1'b0, 1'b1);
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 5'(i), 5'(i + 1), 5'(i + 20), $urandom, $urandom, 5'(i), 1'b1, 1'b0);
      tick();
      chk($sformatf("stall%0d.rd", i), 64'(ex_rd_addr), 64'(14));
      chk($sformatf("stall%0d.val", i), 64'(ex_shift_val), 64'(32'hABCD_0123));
      chk($sformatf("stall%0d.amt", i), 64'(ex_shift_amt), 64'(6));
      chk($sformatf("stall%0d.rw", i), 64'(ex_reg_write), 64'(1));
    end
    flush_i = 1'b1;
    tick();
    chk("flush_stall.valid", 64'(ex_valid), 64'(0));
    chk("flush_stall.rw", 64'(ex_reg_write), 64'(0));
    flush_i = 1'b0; stall_i = 1'b0;

    // back-to-back SRLs: each visible exactly one edge after capture
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 5'd0, 5'(i + 1), 5'(i + 20), 32'h0, 32'(i + 1) * 32'h111, 5'(i + 1), 1'b0, 1'b1);
      tick();
      chk($sformatf("b2b%0d.rd", i), 64'(ex_rd_addr), 64'(i + 20));
      chk($sformatf("b2b%0d.val", i), 64'(ex_shift_val), 64'(32'(i + 1) * 32'h111));
      chk($sformatf("b2b%0d.amt", i), 64'(ex_shift_amt), 64'(i + 1));
    end

    for (int i = 0; i < 400; i++) begin
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      drive_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
               $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      tick();
      check_model("rand");
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      #1 check_model("rand_comb");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
